// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout defaults, arbiter state encodings and
// the clog2 helper used to size index fields.
package noc_pkg;

  localparam int NOC_DATA_W  = 8;
  localparam int NOC_DST_LSB = 4;
  localparam int GAP_CNT_W   = 4;
  localparam int GAP_MAX     = (1 << GAP_CNT_W) - 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_e;

  // Bits needed to index 'value' entries; returns at least 1.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/noc_rr_pick.sv
// Rotate-priority encoder: first set bit of elig at or after ptr, wrapping
// modulo N. Purely combinational so it can sit in front of any grant register.
module noc_rr_pick
  import noc_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = clog2(N)
) (
  input  logic [N-1:0]  elig,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] pick,
  output logic          any
);

  logic [SW-1:0] idx;

  // Scan from the far end back towards ptr so the last hit is the nearest one.
  // N is a power of two, so SW-bit addition gives the modulo wrap for free.
  always_comb begin
    pick = ptr;
    any  = 1'b0;
    idx  = ptr;
    for (int k = N - 1; k >= 0; k--) begin
      idx = ptr + SW'(k);
      if (elig[idx]) begin
        pick = idx;
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_rr_arbiter.sv
// Round-robin input arbiter: picks an eligible FIFO head and offers its
// source/destination pair to the crossbar, with withdrawal and an inter-grant gap.
module noc_rr_arbiter
  import noc_pkg::*;
#(
  parameter int N_PORTS        = 4,
  parameter int DATA_W         = NOC_DATA_W,
  parameter int DST_LSB        = NOC_DST_LSB,
  parameter int GAP_CYCLES     = 0,
  parameter int ALLOW_LOOPBACK = 1,
  localparam int SW            = clog2(N_PORTS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_PORTS-1:0]          fifo_full,
  input  logic [N_PORTS-1:0]          fifo_empty,
  input  logic [N_PORTS*DATA_W-1:0]   head_data,
  output logic [SW-1:0]               source,
  output logic [SW-1:0]               destination,
  output logic                        valid,
  input  logic                        ready,
  output logic                        busy
);

  localparam logic [GAP_CNT_W-1:0] GAP_INIT = GAP_CNT_W'(GAP_CYCLES);

  if (N_PORTS < 2 || (1 << SW) != N_PORTS) begin : g_bad_ports
    $error("noc_rr_arbiter: N_PORTS must be a power of two >= 2");
  end
  if (GAP_CYCLES < 0 || GAP_CYCLES > GAP_MAX) begin : g_bad_gap
    $error("noc_rr_arbiter: GAP_CYCLES out of range");
  end
  if (DST_LSB + SW > DATA_W) begin : g_bad_field
    $error("noc_rr_arbiter: destination field exceeds flit width");
  end

  arb_state_e           state;
  logic [SW-1:0]        ptr;
  logic [GAP_CNT_W-1:0] gap_cnt;

  logic [SW-1:0]        dst [N_PORTS];
  logic [N_PORTS-1:0]   elig;
  logic [SW-1:0]        pick;
  logic                 any;
  logic                 withdraw;

  // Eligibility tracks the current head flit every cycle, so a head that
  // changes while waiting is judged on its own destination.
  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      dst[i]  = head_data[i*DATA_W + DST_LSB +: SW];
      elig[i] = !fifo_empty[i] && !fifo_full[dst[i]] &&
                ((ALLOW_LOOPBACK != 0) || (dst[i] != SW'(i)));
    end
  end

  noc_rr_pick #(
    .N  (N_PORTS),
    .SW (SW)
  ) u_pick (
    .elig (elig),
    .ptr  (ptr),
    .pick (pick),
    .any  (any)
  );

  assign withdraw = fifo_empty[source] || fifo_full[destination];

  // Handshake: a grant transfers on a clk edge where valid && ready. Once
  // valid is raised, source/destination hold until that edge, unless the
  // offer is withdrawn (source drained or destination filled while ready=0);
  // a ready seen in the same cycle as a withdraw condition still transfers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      source      <= '0;
      destination <= '0;
      valid       <= 1'b0;
      busy        <= 1'b0;
      ptr         <= '0;
      gap_cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any) begin
            source      <= pick;
            destination <= dst[pick];
            valid       <= 1'b1;
            busy        <= 1'b1;
            state       <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (ready) begin
            valid <= 1'b0;
            ptr   <= source + SW'(1);
            if (GAP_CYCLES > 0) begin
              gap_cnt <= GAP_INIT;
              state   <= ST_GAP;
            end else begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end else if (withdraw) begin
            valid <= 1'b0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_GAP: begin
          gap_cnt <= gap_cnt - GAP_CNT_W'(1);
          if (gap_cnt <= GAP_CNT_W'(1)) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          valid <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  a_valid_busy : assert property (@(posedge clk) disable iff (!rst_n) valid |-> busy);
  a_valid_state : assert property (@(posedge clk) disable iff (!rst_n)
    valid == (state == ST_OFFER));

endmodule

// File: tb/tb_noc_rr_arbiter.sv
// Directed bench for noc_rr_arbiter: three instances cover the default,
// GAP_CYCLES=3 and ALLOW_LOOPBACK=0 configurations on shared stimulus.
module tb_noc_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  fifo_full;
  logic [3:0]  fifo_empty;
  logic [31:0] head_data;
  logic        ready;

  logic [1:0]  source, destination;
  logic        valid, busy;
  logic [1:0]  g_source, g_destination;
  logic        g_valid, g_busy;
  logic [1:0]  l_source, l_destination;
  logic        l_valid, l_busy;

  int checks = 0;
  int errors = 0;

  noc_rr_arbiter dut (
    .clk (clk), .rst_n (rst_n), .fifo_full (fifo_full), .fifo_empty (fifo_empty),
    .head_data (head_data), .source (source), .destination (destination),
    .valid (valid), .ready (ready), .busy (busy)
  );

  noc_rr_arbiter #(.GAP_CYCLES (3)) dut_gap (
    .clk (clk), .rst_n (rst_n), .fifo_full (fifo_full), .fifo_empty (fifo_empty),
    .head_data (head_data), .source (g_source), .destination (g_destination),
    .valid (g_valid), .ready (ready), .busy (g_busy)
  );

  noc_rr_arbiter #(.ALLOW_LOOPBACK (0)) dut_lb (
    .clk (clk), .rst_n (rst_n), .fifo_full (fifo_full), .fifo_empty (fifo_empty),
    .head_data (head_data), .source (l_source), .destination (l_destination),
    .valid (l_valid), .ready (ready), .busy (l_busy)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Destination in bits [5:4]; surrounding bits are random filler.
  task automatic set_heads(input int d0, input int d1, input int d2, input int d3);
    int d[4];
    d = '{d0, d1, d2, d3};
    for (int i = 0; i < 4; i++) begin
      head_data[i*8 +: 8] = {2'($urandom_range(0, 3)), 2'(d[i]), 4'($urandom_range(0, 15))};
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fifo_empty = 4'b0000; fifo_full = 4'b0000; ready = 1'b0;
    set_heads(2, 3, 0, 1);
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid c%0d: got %b want 0", c, valid); end
      checks++;
      if (source !== 2'd0) begin errors++; $display("FAIL reset_source c%0d: got %0d want 0", c, source); end
      checks++;
      if (destination !== 2'd0) begin errors++; $display("FAIL reset_dest c%0d: got %0d want 0", c, destination); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy c%0d: got %b want 0", c, busy); end
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (valid !== 1'b1) begin errors++; $display("FAIL reset_first_valid: got %b want 1", valid); end
    checks++;
    if (source !== 2'd0) begin errors++; $display("FAIL reset_first_source: got %0d want 0", source); end
    checks++;
    if (destination !== 2'd2) begin errors++; $display("FAIL reset_first_dest: got %0d want 2", destination); end
  endtask

  task automatic test_round_robin();
    fifo_empty = 4'b0000; fifo_full = 4'b0000; ready = 1'b1;
    set_heads(2, 3, 0, 1);
    do_reset();
    for (int g = 0; g < 5; g++) begin
      step();
      checks++;
      if (valid !== 1'b1) begin errors++; $display("FAIL rr_valid g%0d: got %b want 1", g, valid); end
      checks++;
      if (source !== 2'(g % 4)) begin errors++; $display("FAIL rr_source g%0d: got %0d want %0d", g, source, g % 4); end
      checks++;
      if (destination !== 2'((g + 2) % 4)) begin
        errors++; $display("FAIL rr_dest g%0d: got %0d want %0d", g, destination, (g + 2) % 4);
      end
      step();
      checks++;
      if (valid !== 1'b0) begin errors++; $display("FAIL rr_gap_valid g%0d: got %b want 0", g, valid); end
    end
  endtask

  task automatic test_full_dest();
    fifo_empty = 4'b0101; fifo_full = 4'b0100; ready = 1'b1;
    set_heads(0, 2, 0, 2);
    do_reset();
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (valid !== 1'b0) begin errors++; $display("FAIL full_blocked c%0d: got %b want 0", c, valid); end
    end
    fifo_full = 4'b0000;
    step();
    checks++;
    if (valid !== 1'b1 || source !== 2'd1 || destination !== 2'd2) begin
      errors++; $display("FAIL full_first: got v=%b s=%0d d=%0d want v=1 s=1 d=2", valid, source, destination);
    end
    step();
    step();
    checks++;
    if (valid !== 1'b1 || source !== 2'd3 || destination !== 2'd2) begin
      errors++; $display("FAIL full_second: got v=%b s=%0d d=%0d want v=1 s=3 d=2", valid, source, destination);
    end
  endtask

  task automatic test_withdraw();
    fifo_empty = 4'b1011; fifo_full = 4'b0000; ready = 1'b0;
    set_heads(1, 2, 0, 1);
    do_reset();
    step();
    step();
    checks++;
    if (valid !== 1'b1 || source !== 2'd2 || destination !== 2'd0) begin
      errors++; $display("FAIL wd_offer: got v=%b s=%0d d=%0d want v=1 s=2 d=0", valid, source, destination);
    end
    fifo_full = 4'b0001;
    step();
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL wd_drop: got v=%b b=%b want v=0 b=0", valid, busy);
    end
    checks++;
    if (dut.ptr !== 2'd0) begin errors++; $display("FAIL wd_ptr: got %0d want 0", dut.ptr); end
    step();
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL wd_hold: got %b want 0", valid); end
    fifo_full = 4'b0000;
    step();
    checks++;
    if (valid !== 1'b1 || source !== 2'd2) begin
      errors++; $display("FAIL wd_reoffer: got v=%b s=%0d want v=1 s=2", valid, source);
    end
    // ready and a withdraw condition together: the handshake is taken.
    ready = 1'b1; fifo_full = 4'b0001;
    step();
    checks++;
    if (valid !== 1'b0 || dut.ptr !== 2'd3) begin
      errors++; $display("FAIL wd_race: got v=%b ptr=%0d want v=0 ptr=3", valid, dut.ptr);
    end
  endtask

  task automatic test_gap();
    fifo_empty = 4'b0000; fifo_full = 4'b0000; ready = 1'b1;
    set_heads(2, 3, 0, 1);
    do_reset();
    for (int k = 0; k < 11; k++) begin
      step();
      checks++;
      if (g_valid !== (k % 5 == 0)) begin
        errors++; $display("FAIL gap_valid k%0d: got %b want %b", k, g_valid, (k % 5 == 0));
      end
      checks++;
      if (g_busy !== (k % 5 != 4)) begin
        errors++; $display("FAIL gap_busy k%0d: got %b want %b", k, g_busy, (k % 5 != 4));
      end
      checks++;
      if (g_source !== 2'(k / 5)) begin
        errors++; $display("FAIL gap_source k%0d: got %0d want %0d", k, g_source, k / 5);
      end
    end
  endtask

  task automatic test_loopback_reset();
    int exp_src[5];
    int exp_dst[5];
    exp_src = '{0, 2, 3, 0, 2};
    exp_dst = '{2, 0, 0, 2, 0};
    fifo_empty = 4'b0000; fifo_full = 4'b0000; ready = 1'b1;
    set_heads(2, 1, 0, 0);
    do_reset();
    for (int g = 0; g < 5; g++) begin
      step();
      checks++;
      if (l_valid !== 1'b1 || l_source !== 2'(exp_src[g]) || l_destination !== 2'(exp_dst[g])) begin
        errors++;
        $display("FAIL lb_grant g%0d: got v=%b s=%0d d=%0d want v=1 s=%0d d=%0d",
                 g, l_valid, l_source, l_destination, exp_src[g], exp_dst[g]);
      end
      step();
      checks++;
      if (l_valid !== 1'b0) begin errors++; $display("FAIL lb_idle g%0d: got %b want 0", g, l_valid); end
    end
    ready = 1'b0;
    step();
    checks++;
    if (l_valid !== 1'b1 || l_source !== 2'd3) begin
      errors++; $display("FAIL lb_offer: got v=%b s=%0d want v=1 s=3", l_valid, l_source);
    end
    rst_n = 1'b0;
    step();
    checks++;
    if (l_valid !== 1'b0 || l_busy !== 1'b0 || l_source !== 2'd0 || l_destination !== 2'd0) begin
      errors++; $display("FAIL lb_rst_out: got v=%b b=%b s=%0d d=%0d want all 0", l_valid, l_busy, l_source, l_destination);
    end
    checks++;
    if (dut_lb.ptr !== 2'd0 || dut_lb.state !== noc_pkg::ST_IDLE) begin
      errors++; $display("FAIL lb_rst_state: got ptr=%0d st=%0d want ptr=0 st=0", dut_lb.ptr, dut_lb.state);
    end
    rst_n = 1'b1; ready = 1'b1;
    step();
    checks++;
    if (l_valid !== 1'b1 || l_source !== 2'd0) begin
      errors++; $display("FAIL lb_after_rst: got v=%b s=%0d want v=1 s=0", l_valid, l_source);
    end
  endtask

  // Sequence and final report
  initial begin
    rst_n = 1'b0; fifo_empty = 4'hf; fifo_full = 4'h0; head_data = '0; ready = 1'b0;
    test_reset();
    test_round_robin();
    test_full_dest();
    test_withdraw();
    test_gap();
    test_loopback_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
